// File: rtl/health_led_if.sv
`timescale 1ns/1ps
// Status request / LED status bundle between the board controller and the
// health LED sequencer.
interface health_led_if;
  logic       ok_req;
  logic       warn_req;
  logic       fault_req;
  logic       fault_clear;
  logic       led_out;
  logic [1:0] state_code;
  logic       fault_latched;

  // Requester side: drives the status levels, observes the LED and status.
  modport master (
    output ok_req, warn_req, fault_req, fault_clear,
    input  led_out, state_code, fault_latched
  );

  // Sequencer side.
  modport slave (
    input  ok_req, warn_req, fault_req, fault_clear,
    output led_out, state_code, fault_latched
  );
endinterface

// File: rtl/health_led_sequencer.sv
`timescale 1ns/1ps
// Health LED sequencer: chooses the highest-priority status (FAULT > WARN >
// OK > IDLE), holds a status for a minimum time before a downgrade, and
// drives off / solid / slow blink / fast blink patterns. Faults are sticky
// until cleared.
module health_led_sequencer #(
  parameter int TICK_DIV  = 4,
  parameter int SLOW_HALF = 8,
  parameter int FAST_HALF = 2,
  parameter int MIN_HOLD  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  health_led_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OK    = 2'd1;
  localparam logic [1:0] ST_WARN  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int PRESC_W  = $clog2(TICK_DIV);
  localparam int PHASE_W  = $clog2(MAX_HALF + 1);
  localparam int HOLD_W   = $clog2(MIN_HOLD + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PHASE_W-1:0] SLOW_LAST  = PHASE_W'(SLOW_HALF - 1);
  localparam logic [PHASE_W-1:0] FAST_LAST  = PHASE_W'(FAST_HALF - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MIN_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_PRE   = HOLD_W'(MIN_HOLD - 1);

  logic [1:0]         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               led_q, led_d;
  logic               fault_latched_q, fault_latched_d;

  logic [1:0]         target;
  logic               tick;
  logic               hold_done;
  logic               hold_ends;
  logic [PHASE_W-1:0] half_last;

  // Sticky fault flag: a live fault request always wins over a clear.
  always_comb begin
    fault_latched_d = fault_latched_q;
    if (bus.fault_req) begin
      fault_latched_d = 1'b1;
    end else if (bus.fault_clear) begin
      fault_latched_d = 1'b0;
    end
  end

  // Highest-priority requested status.
  always_comb begin
    target = ST_IDLE;
    if (bus.fault_req || fault_latched_q) begin
      target = ST_FAULT;
    end else if (bus.warn_req) begin
      target = ST_WARN;
    end else if (bus.ok_req) begin
      target = ST_OK;
    end
  end

  // Next state, tick prescaler, hold timer and blink pattern.
  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    hold_done = (hold_q == HOLD_MAX);
    // Downgrade is allowed on the very edge where the hold counter reaches
    // MIN_HOLD, so a status is shown for exactly MIN_HOLD*TICK_DIV cycles.
    hold_ends = hold_done || (tick && (hold_q == HOLD_PRE));
    half_last = (state_q == ST_FAULT) ? FAST_LAST : SLOW_LAST;

    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    hold_d  = (tick && !hold_done) ? hold_q + 1'b1 : hold_q;
    phase_d = phase_q;
    led_d   = led_q;

    case (state_q)
      ST_IDLE: led_d = 1'b0;
      ST_OK:   led_d = 1'b1;
      default: begin
        if (tick) begin
          if (phase_q == half_last) begin
            phase_d = '0;
            led_d   = ~led_q;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
    endcase

    // Entering a new status restarts every counter and the pattern high.
    if ((target > state_q) || ((target < state_q) && hold_ends)) begin
      state_d = target;
      presc_d = '0;
      hold_d  = '0;
      phase_d = '0;
      led_d   = (target != ST_IDLE);
    end
  end

  // State registers; reset forces IDLE with LED off and everything cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      presc_q         <= '0;
      phase_q         <= '0;
      hold_q          <= '0;
      led_q           <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      presc_q         <= presc_d;
      phase_q         <= phase_d;
      hold_q          <= hold_d;
      led_q           <= led_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  assign bus.led_out       = led_q;
  assign bus.state_code    = state_q;
  assign bus.fault_latched = fault_latched_q;

endmodule

// File: tb/tb_health_led_sequencer.sv
`timescale 1ns/1ps
// Directed testbench for health_led_sequencer with default parameters
// (TICK_DIV=4, SLOW_HALF=8, FAST_HALF=2, MIN_HOLD=16): WARN blinks 32/32,
// FAULT blinks 8/8, minimum display 64 cycles.
module tb_health_led_sequencer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  health_led_if bus_if ();

  health_led_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the run ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle just after it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking reset pulse with all requests low.
  task automatic do_reset;
    bus_if.ok_req      = 1'b0;
    bus_if.warn_req    = 1'b0;
    bus_if.fault_req   = 1'b0;
    bus_if.fault_clear = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if ({bus_if.led_out, bus_if.state_code, bus_if.fault_latched} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000",
               {bus_if.led_out, bus_if.state_code, bus_if.fault_latched});
    end
    for (int i = 0; i < 50; i++) begin
      step();
      n_tests++;
      if ({bus_if.led_out, bus_if.state_code, bus_if.fault_latched} !== 4'b0) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d: got %b required 0000", i,
                 {bus_if.led_out, bus_if.state_code, bus_if.fault_latched});
      end
    end
    bus_if.ok_req = 1'b1;
    step();
    n_tests++;
    if (bus_if.state_code !== 2'd1 || bus_if.led_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ok_entry: state %0d led %b required state 1 led 1",
               bus_if.state_code, bus_if.led_out);
    end
  endtask

  // Continues from OK: WARN upgrade, 32 high / 32 low blink.
  task automatic test_warn_blink;
    logic exp_led;
    bus_if.warn_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      exp_led = (((i / 32) % 2) == 0);
      n_tests++;
      if (bus_if.state_code !== 2'd2 || bus_if.led_out !== exp_led) begin
        n_fail++;
        $display("FAIL warn_blink cycle %0d: state %0d led %b required state 2 led %b",
                 i, bus_if.state_code, bus_if.led_out, exp_led);
      end
    end
  endtask

  // Continues from WARN with hold done: 1-cycle fault pulse latches FAULT.
  task automatic test_fault_latch;
    logic exp_led;
    bus_if.fault_req = 1'b1;
    step();
    bus_if.fault_req = 1'b0;
    n_tests++;
    if (bus_if.state_code !== 2'd3 || bus_if.fault_latched !== 1'b1 || bus_if.led_out !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_entry: state %0d latched %b led %b required 3 1 1",
               bus_if.state_code, bus_if.fault_latched, bus_if.led_out);
    end
    for (int i = 1; i < 72; i++) begin
      step();
      exp_led = (((i / 8) % 2) == 0);
      n_tests++;
      if (bus_if.state_code !== 2'd3 || bus_if.led_out !== exp_led) begin
        n_fail++;
        $display("FAIL fault_blink cycle %0d: state %0d led %b required state 3 led %b",
                 i, bus_if.state_code, bus_if.led_out, exp_led);
      end
    end
    bus_if.fault_clear = 1'b1;
    step();
    bus_if.fault_clear = 1'b0;
    n_tests++;
    if (bus_if.fault_latched !== 1'b0 || bus_if.state_code !== 2'd3 || bus_if.led_out !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clear_edge: latched %b state %0d led %b required 0 3 0",
               bus_if.fault_latched, bus_if.state_code, bus_if.led_out);
    end
    step();
    n_tests++;
    if (bus_if.state_code !== 2'd2 || bus_if.led_out !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_warn: state %0d led %b required state 2 led 1",
               bus_if.state_code, bus_if.led_out);
    end
    for (int i = 1; i < 40; i++) begin
      step();
      exp_led = (((i / 32) % 2) == 0);
      n_tests++;
      if (bus_if.state_code !== 2'd2 || bus_if.led_out !== exp_led) begin
        n_fail++;
        $display("FAIL warn_restart cycle %0d: state %0d led %b required state 2 led %b",
                 i, bus_if.state_code, bus_if.led_out, exp_led);
      end
    end
  endtask

  // Short WARN glitch from OK: shown for exactly 64 cycles, then OK.
  task automatic test_warn_hold;
    logic exp_led;
    do_reset();
    bus_if.ok_req = 1'b1;
    step();
    bus_if.warn_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (i == 2) bus_if.warn_req = 1'b0;
      exp_led = (((i / 32) % 2) == 0);
      n_tests++;
      if (bus_if.state_code !== 2'd2 || bus_if.led_out !== exp_led) begin
        n_fail++;
        $display("FAIL warn_hold cycle %0d: state %0d led %b required state 2 led %b",
                 i, bus_if.state_code, bus_if.led_out, exp_led);
      end
    end
    step();
    n_tests++;
    if (bus_if.state_code !== 2'd1 || bus_if.led_out !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: state %0d led %b required state 1 led 1",
               bus_if.state_code, bus_if.led_out);
    end
  endtask

  // Fault and clear together keep the latch; a later lone clear releases it,
  // after which the downgrade still waits for the hold time.
  task automatic test_fault_clear_conflict;
    logic exp_led;
    do_reset();
    bus_if.ok_req = 1'b1;
    step();
    bus_if.fault_req   = 1'b1;
    bus_if.fault_clear = 1'b1;
    step();
    n_tests++;
    if (bus_if.fault_latched !== 1'b1 || bus_if.state_code !== 2'd3) begin
      n_fail++;
      $display("FAIL set_beats_clear: latched %b state %0d required 1 3",
               bus_if.fault_latched, bus_if.state_code);
    end
    bus_if.fault_req = 1'b0;
    step();
    bus_if.fault_clear = 1'b0;
    n_tests++;
    if (bus_if.fault_latched !== 1'b0 || bus_if.state_code !== 2'd3) begin
      n_fail++;
      $display("FAIL lone_clear: latched %b state %0d required 0 3",
               bus_if.fault_latched, bus_if.state_code);
    end
    for (int i = 2; i < 64; i++) begin
      step();
      exp_led = (((i / 8) % 2) == 0);
      n_tests++;
      if (bus_if.state_code !== 2'd3 || bus_if.led_out !== exp_led) begin
        n_fail++;
        $display("FAIL fault_hold cycle %0d: state %0d led %b required state 3 led %b",
                 i, bus_if.state_code, bus_if.led_out, exp_led);
      end
    end
    step();
    n_tests++;
    if (bus_if.state_code !== 2'd1 || bus_if.led_out !== 1'b1 || bus_if.fault_latched !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_to_ok: state %0d led %b latched %b required 1 1 0",
               bus_if.state_code, bus_if.led_out, bus_if.fault_latched);
    end
  endtask

  // Asynchronous reset between clock edges while FAULT is blinking.
  task automatic test_async_reset;
    do_reset();
    bus_if.fault_req = 1'b1;
    step();
    bus_if.fault_req = 1'b0;
    repeat (5) step();
    n_tests++;
    if (bus_if.state_code !== 2'd3 || bus_if.led_out !== 1'b1 || bus_if.fault_latched !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_fault: state %0d led %b latched %b required 3 1 1",
               bus_if.state_code, bus_if.led_out, bus_if.fault_latched);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus_if.led_out, bus_if.state_code, bus_if.fault_latched} !== 4'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b required 0000",
               {bus_if.led_out, bus_if.state_code, bus_if.fault_latched});
    end
    bus_if.ok_req = 1'b1;
    #2;
    rst_n = 1'b1;
    step();
    n_tests++;
    if (bus_if.state_code !== 2'd1 || bus_if.led_out !== 1'b1 || bus_if.fault_latched !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_ok: state %0d led %b latched %b required 1 1 0",
               bus_if.state_code, bus_if.led_out, bus_if.fault_latched);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus_if.ok_req      = 1'b0;
    bus_if.warn_req    = 1'b0;
    bus_if.fault_req   = 1'b0;
    bus_if.fault_clear = 1'b0;
    test_reset();
    test_warn_blink();
    test_fault_latch();
    test_warn_hold();
    test_fault_clear_conflict();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
